// File: rtl/median_level_detector.sv
// Hysteresis level detector for the median filter output stream: N-sample confirmed
// level changes, rise/fall pulses, per-episode peak capture and a saturating rise counter.
module median_level_detector #(
  parameter int WIDTH   = 16,
  parameter int CONFIRM = 4,
  parameter int CNT_W   = 16
) (
  input  logic             ck100m,
  input  logic             srst,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] th_hi,
  input  logic [WIDTH-1:0] th_lo,
  output logic             level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [WIDTH-1:0] peak,
  output logic             peak_valid,
  output logic [CNT_W-1:0] event_cnt,
  output logic             cfg_err
);

  localparam int CW = $clog2(CONFIRM + 1);
  localparam logic [CW-1:0] CONF_N = CW'(CONFIRM);

  typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;

  state_t           state;
  logic [CW-1:0]    conf_cnt;
  logic [WIDTH-1:0] run_max;

  logic             qual_hi;
  logic             qual_lo;
  logic [WIDTH-1:0] max_in;
  logic [CW-1:0]    conf_next;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    qual_hi   = (in >= th_hi);
    qual_lo   = (in <= th_lo);
    max_in    = (in > run_max) ? in : run_max;
    conf_next = conf_cnt + 1'b1;
    cnt_inc   = (event_cnt == '1) ? event_cnt : event_cnt + 1'b1;
  end

  always_ff @(posedge ck100m) begin
    if (srst) begin
      state      <= LOW;
      conf_cnt   <= '0;
      run_max    <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      peak       <= '0;
      peak_valid <= 1'b0;
      event_cnt  <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err    <= (th_lo > th_hi);
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      peak_valid <= 1'b0;
      if (enable) begin
        // A bad threshold pair silently abandons any episode: no pulses, no peak.
        if (cfg_err) begin
          state    <= LOW;
          conf_cnt <= '0;
          run_max  <= '0;
          level    <= 1'b0;
        end else begin
          case (state)
            LOW: begin
              if (qual_hi) begin
                run_max <= in;
                if (CONFIRM == 1) begin
                  state      <= HIGH;
                  level      <= 1'b1;
                  rise_pulse <= 1'b1;
                  event_cnt  <= cnt_inc;
                end else begin
                  state    <= RISE_PEND;
                  conf_cnt <= CW'(1);
                end
              end
            end
            RISE_PEND: begin
              if (qual_hi) begin
                run_max <= max_in;
                if (conf_next == CONF_N) begin
                  state      <= HIGH;
                  level      <= 1'b1;
                  rise_pulse <= 1'b1;
                  event_cnt  <= cnt_inc;
                  conf_cnt   <= '0;
                end else begin
                  conf_cnt <= conf_next;
                end
              end else begin
                state    <= LOW;
                conf_cnt <= '0;
                run_max  <= '0;
              end
            end
            HIGH: begin
              run_max <= max_in;
              if (qual_lo) begin
                if (CONFIRM == 1) begin
                  state      <= LOW;
                  level      <= 1'b0;
                  fall_pulse <= 1'b1;
                  peak_valid <= 1'b1;
                  peak       <= max_in;
                end else begin
                  state    <= FALL_PEND;
                  conf_cnt <= CW'(1);
                end
              end
            end
            FALL_PEND: begin
              run_max <= max_in;
              if (qual_lo) begin
                if (conf_next == CONF_N) begin
                  state      <= LOW;
                  level      <= 1'b0;
                  fall_pulse <= 1'b1;
                  peak_valid <= 1'b1;
                  peak       <= max_in;
                  conf_cnt   <= '0;
                end else begin
                  conf_cnt <= conf_next;
                end
              end else begin
                state    <= HIGH;
                conf_cnt <= '0;
              end
            end
            default: begin
              state    <= LOW;
              conf_cnt <= '0;
              run_max  <= '0;
              level    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_median_level_detector.sv
// Bench for median_level_detector: three parameterisations share one stimulus stream and
// are compared against a count-based behavioural model plus directed scenario constants.
module tb_median_level_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst, enable;
  logic [15:0] din, th_hi, th_lo;

  logic [2:0]  level_o, rise_o, fall_o, pv_o, cerr_o;
  logic [15:0] peak_o [3];
  logic [15:0] evt0, evt2;
  logic [1:0]  evt1;
  logic [15:0] evt_o [3];
  assign evt_o[0] = evt0;
  assign evt_o[1] = {14'b0, evt1};
  assign evt_o[2] = evt2;

  median_level_detector #(.WIDTH(16), .CONFIRM(4), .CNT_W(16)) u_main (
    .ck100m(clk), .srst(srst), .enable(enable), .in(din), .th_hi(th_hi), .th_lo(th_lo),
    .level(level_o[0]), .rise_pulse(rise_o[0]), .fall_pulse(fall_o[0]), .peak(peak_o[0]),
    .peak_valid(pv_o[0]), .event_cnt(evt0), .cfg_err(cerr_o[0]));

  median_level_detector #(.WIDTH(16), .CONFIRM(4), .CNT_W(2)) u_sat (
    .ck100m(clk), .srst(srst), .enable(enable), .in(din), .th_hi(th_hi), .th_lo(th_lo),
    .level(level_o[1]), .rise_pulse(rise_o[1]), .fall_pulse(fall_o[1]), .peak(peak_o[1]),
    .peak_valid(pv_o[1]), .event_cnt(evt1), .cfg_err(cerr_o[1]));

  median_level_detector #(.WIDTH(16), .CONFIRM(1), .CNT_W(16)) u_one (
    .ck100m(clk), .srst(srst), .enable(enable), .in(din), .th_hi(th_hi), .th_lo(th_lo),
    .level(level_o[2]), .rise_pulse(rise_o[2]), .fall_pulse(fall_o[2]), .peak(peak_o[2]),
    .peak_valid(pv_o[2]), .event_cnt(evt2), .cfg_err(cerr_o[2]));

  int checks = 0;
  int errors = 0;

  // Reference model: a level bit plus a streak of consecutive qualifying samples.
  int CONF [3] = '{4, 4, 1};
  int CMAX [3] = '{65535, 3, 65535};
  bit m_lvl [3], m_rise [3], m_fall [3], m_pv [3], m_cerr [3];
  int m_streak [3], m_mx [3], m_peak [3], m_evt [3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_lvl[k] = 0; m_rise[k] = 0; m_fall[k] = 0; m_pv[k] = 0; m_cerr[k] = 0;
      m_streak[k] = 0; m_mx[k] = 0; m_peak[k] = 0; m_evt[k] = 0;
    end
  endfunction

  function automatic void model_step(bit en, int x, int hi, int lo);
    for (int k = 0; k < 3; k++) begin
      m_rise[k] = 0; m_fall[k] = 0; m_pv[k] = 0;
      if (en) begin
        if (m_cerr[k]) begin
          m_lvl[k] = 0; m_streak[k] = 0; m_mx[k] = 0;
        end else if (!m_lvl[k]) begin
          if (x >= hi) begin
            m_mx[k] = (m_streak[k] == 0) ? x : ((x > m_mx[k]) ? x : m_mx[k]);
            m_streak[k]++;
            if (m_streak[k] >= CONF[k]) begin
              m_lvl[k] = 1; m_streak[k] = 0; m_rise[k] = 1;
              if (m_evt[k] < CMAX[k]) m_evt[k]++;
            end
          end else begin
            m_streak[k] = 0; m_mx[k] = 0;
          end
        end else begin
          if (x > m_mx[k]) m_mx[k] = x;
          if (x <= lo) begin
            m_streak[k]++;
            if (m_streak[k] >= CONF[k]) begin
              m_lvl[k] = 0; m_streak[k] = 0; m_fall[k] = 1; m_pv[k] = 1; m_peak[k] = m_mx[k];
            end
          end else begin
            m_streak[k] = 0;
          end
        end
      end
      m_cerr[k] = (lo > hi);
    end
  endfunction

  task automatic sample(input bit en, input int x);
    @(negedge clk);
    srst = 1'b0; enable = en; din = 16'(x);
    @(posedge clk);
    model_step(en, x, int'(th_hi), int'(th_lo));
    #1;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      srst = 1'b1; enable = 1'($urandom); din = 16'($urandom);
      @(posedge clk);
      model_reset();
      #1;
    end
  endtask

  task automatic go_high();
    for (int i = 0; i < 4; i++) sample(1, 1100);
  endtask

  task automatic go_low();
    for (int i = 0; i < 4; i++) sample(1, 300);
  endtask

  task automatic test_reset();
    th_hi = 16'd1000; th_lo = 16'd500;
    reset_cycles(3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({level_o[k], rise_o[k], fall_o[k], pv_o[k], cerr_o[k]} !== 5'b0 || peak_o[k] !== 16'd0 || evt_o[k] !== 16'd0) begin
        errors++;
        $display("FAIL reset[%0d]: lvl/rise/fall/pv/cerr=%b%b%b%b%b peak=%0d evt=%0d, required all 0",
                 k, level_o[k], rise_o[k], fall_o[k], pv_o[k], cerr_o[k], peak_o[k], evt_o[k]);
      end
    end
    for (int i = 0; i < 3; i++) sample(0, $urandom_range(0, 2000));
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (level_o[k] !== 1'b0 || rise_o[k] !== 1'b0 || evt_o[k] !== 16'd0) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: level=%b rise=%b evt=%0d, required 0 0 0", k, level_o[k], rise_o[k], evt_o[k]);
      end
    end
  endtask

  task automatic test_rise_confirm();
    int seq [3] = '{1000, 1200, 1100};
    for (int i = 0; i < 3; i++) begin
      sample(1, seq[i]);
      checks++;
      if (level_o[0] !== 1'b0 || rise_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL rise_early s%0d: level=%b rise=%b, required 0 0", i, level_o[0], rise_o[0]);
      end
      if (i == 0) begin
        checks++;
        if (rise_o[2] !== 1'b1 || level_o[2] !== 1'b1 || evt_o[2] !== 16'd1) begin
          errors++;
          $display("FAIL rise_confirm1: rise=%b level=%b evt=%0d, required 1 1 1", rise_o[2], level_o[2], evt_o[2]);
        end
      end
    end
    sample(1, 1050);
    checks++;
    if (rise_o[0] !== 1'b1 || level_o[0] !== 1'b1 || evt_o[0] !== 16'd1) begin
      errors++;
      $display("FAIL rise_confirm: rise=%b level=%b evt=%0d, required 1 1 1", rise_o[0], level_o[0], evt_o[0]);
    end
    sample(0, 0);
    checks++;
    if (rise_o[0] !== 1'b0 || level_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL rise_one_cycle: rise=%b level=%b, required 0 1", rise_o[0], level_o[0]);
    end
    go_low();
    seq = '{1000, 1200, 999};
    for (int i = 0; i < 3; i++) begin
      sample(1, seq[i]);
      checks++;
      if (rise_o[0] !== 1'b0 || level_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL rise_broken s%0d: rise=%b level=%b, required 0 0", i, rise_o[0], level_o[0]);
      end
    end
  endtask

  task automatic test_fall_peak();
    int seq [5] = '{1500, 800, 500, 400, 300};
    go_high();
    for (int i = 0; i < 5; i++) begin
      sample(1, seq[i]);
      checks++;
      if (fall_o[0] !== 1'b0 || level_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL fall_early s%0d: fall=%b level=%b, required 0 1", i, fall_o[0], level_o[0]);
      end
    end
    sample(1, 500);
    checks++;
    if (fall_o[0] !== 1'b1 || pv_o[0] !== 1'b1 || peak_o[0] !== 16'd1500 || level_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL fall_peak: fall=%b pv=%b peak=%0d level=%b, required 1 1 1500 0", fall_o[0], pv_o[0], peak_o[0], level_o[0]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fall_o[k] !== m_fall[k] || peak_o[k] !== 16'(m_peak[k])) begin
        errors++;
        $display("FAIL fall_model[%0d]: fall=%b peak=%0d, required %b %0d", k, fall_o[k], peak_o[k], m_fall[k], m_peak[k]);
      end
    end
    go_high();
    seq = '{500, 400, 501, 300, 200};
    for (int i = 0; i < 5; i++) begin
      sample(1, seq[i]);
      checks++;
      if (fall_o[0] !== 1'b0 || pv_o[0] !== 1'b0 || level_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL fall_interrupted s%0d: fall=%b pv=%b level=%b, required 0 0 1", i, fall_o[0], pv_o[0], level_o[0]);
      end
    end
    sample(1, 100);
    sample(1, 100);
    checks++;
    if (fall_o[0] !== 1'b1 || peak_o[0] !== 16'd1100) begin
      errors++;
      $display("FAIL fall_after_restart: fall=%b peak=%0d, required 1 1100", fall_o[0], peak_o[0]);
    end
  endtask

  task automatic test_hysteresis();
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) go_high();
      for (int i = 0; i < 30; i++) begin
        sample(1, $urandom_range(600, 900));
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (rise_o[k] !== 1'b0 || fall_o[k] !== 1'b0 || level_o[k] !== 1'(phase)) begin
            errors++;
            $display("FAIL hysteresis[%0d] ph%0d: rise=%b fall=%b level=%b, required 0 0 %0d", k, phase, rise_o[k], fall_o[k], level_o[k], phase);
          end
        end
      end
    end
    go_low();
  endtask

  task automatic test_equal_thresholds();
    th_hi = 16'd800; th_lo = 16'd800;
    for (int i = 0; i < 8; i++) begin
      sample(1, 800);
      checks++;
      if (rise_o[0] !== 1'(i == 3) || fall_o[0] !== 1'(i == 7) || level_o[0] !== 1'(i >= 3 && i < 7)) begin
        errors++;
        $display("FAIL equal_th s%0d: rise=%b fall=%b level=%b", i, rise_o[0], fall_o[0], level_o[0]);
      end
    end
    checks++;
    if (peak_o[0] !== 16'd800) begin
      errors++;
      $display("FAIL equal_th_peak: peak=%0d, required 800", peak_o[0]);
    end
    th_hi = 16'd1000; th_lo = 16'd500;
  endtask

  task automatic test_cfg_err();
    go_high();
    th_lo = 16'd1200; th_hi = 16'd1000;
    sample(0, 0);
    checks++;
    if (cerr_o[0] !== 1'b1 || level_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_set: cfg_err=%b level=%b, required 1 1", cerr_o[0], level_o[0]);
    end
    sample(1, 1100);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cerr_o[k] !== 1'b1 || level_o[k] !== 1'b0 || fall_o[k] !== 1'b0 || pv_o[k] !== 1'b0 || rise_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_force[%0d]: cfg_err=%b level=%b fall=%b pv=%b rise=%b, required 1 0 0 0 0",
                 k, cerr_o[k], level_o[k], fall_o[k], pv_o[k], rise_o[k]);
      end
    end
    th_lo = 16'd500; th_hi = 16'd1000;
    sample(0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cerr_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_clear[%0d]: cfg_err=%b, required 0", k, cerr_o[k]);
      end
    end
    go_high();
    checks++;
    if (rise_o[0] !== 1'b1 || level_o[0] !== 1'b1 || evt_o[0] !== 16'(m_evt[0])) begin
      errors++;
      $display("FAIL cfg_err_resume: rise=%b level=%b evt=%0d, required 1 1 %0d", rise_o[0], level_o[0], evt_o[0], m_evt[0]);
    end
    go_low();
  endtask

  task automatic test_saturation();
    reset_cycles(1);
    for (int e = 1; e <= 5; e++) begin
      go_high();
      checks++;
      if (rise_o[1] !== 1'b1 || evt_o[1] !== 16'((e > 3) ? 3 : e)) begin
        errors++;
        $display("FAIL saturation ep%0d: rise=%b evt=%0d, required 1 %0d", e, rise_o[1], evt_o[1], (e > 3) ? 3 : e);
      end
      go_low();
      checks++;
      if (fall_o[1] !== 1'b1) begin
        errors++;
        $display("FAIL saturation_fall ep%0d: fall=%b, required 1", e, fall_o[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    go_high();
    sample(1, 1500);
    sample(1, 300);
    sample(1, 300);
    checks++;
    if (level_o[0] !== 1'b1 || fall_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_pending: level=%b fall=%b, required 1 0", level_o[0], fall_o[0]);
    end
    reset_cycles(1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pv_o[k] !== 1'b0 || fall_o[k] !== 1'b0 || peak_o[k] !== 16'd0 || level_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset[%0d]: pv=%b fall=%b peak=%0d level=%b, required 0 0 0 0", k, pv_o[k], fall_o[k], peak_o[k], level_o[k]);
      end
    end
    sample(1, 300);
    sample(1, 300);
    checks++;
    if (pv_o[0] !== 1'b0 || fall_o[0] !== 1'b0 || peak_o[0] !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_after: pv=%b fall=%b peak=%0d, required 0 0 0", pv_o[0], fall_o[0], peak_o[0]);
    end
  endtask

  task automatic test_random();
    int hi, lo, x, r;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        hi = $urandom_range(0, 2000);
        r  = $urandom_range(0, 9);
        lo = (r < 7) ? $urandom_range(0, hi) : ((r < 8) ? hi : $urandom_range(0, 2000));
        th_hi = 16'(hi); th_lo = 16'(lo);
      end
      hi = int'(th_hi); lo = int'(th_lo);
      r = $urandom_range(0, 9);
      x = (r < 4) ? $urandom_range(hi, 2100) : ((r < 8) ? $urandom_range(0, lo) : $urandom_range(0, 2100));
      if ($urandom_range(0, 199) == 0) reset_cycles(1);
      else sample(($urandom_range(0, 3) != 0), x);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (level_o[k] !== m_lvl[k] || rise_o[k] !== m_rise[k] || fall_o[k] !== m_fall[k] || pv_o[k] !== m_pv[k] ||
            cerr_o[k] !== m_cerr[k] || peak_o[k] !== 16'(m_peak[k]) || evt_o[k] !== 16'(m_evt[k])) begin
          errors++;
          $display("FAIL random[%0d] n=%0d: lvl/rise/fall/pv/cerr=%b%b%b%b%b peak=%0d evt=%0d, required %b%b%b%b%b peak=%0d evt=%0d",
                   k, n, level_o[k], rise_o[k], fall_o[k], pv_o[k], cerr_o[k], peak_o[k], evt_o[k],
                   m_lvl[k], m_rise[k], m_fall[k], m_pv[k], m_cerr[k], m_peak[k], m_evt[k]);
        end
      end
    end
  endtask

  initial begin
    srst = 1'b1; enable = 1'b0; din = '0; th_hi = 16'd1000; th_lo = 16'd500;
    model_reset();
    test_reset();
    test_rise_confirm();
    test_fall_peak();
    test_hysteresis();
    test_equal_thresholds();
    test_cfg_err();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
